id_ex_register: RTL

Decode-to-execute pipeline register of the SIMD AES processor. It captures the control word produced by the decode-stage control unit, together with operands and the destination register, and presents them to the execute stage. It also sequences multi-beat vector instructions: it holds a vector instruction in E for VEC_BEATS cycles and drives Stuck back to decode/fetch while it does so. Stall and flush requests from the hazard unit are applied here.

---
 rtl/id_ex_register.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/id_ex_register.sv
// Decode-to-execute pipeline register with multi-beat vector sequencing.
// Optional flush/bubble counter enabled by defining IDEX_BUBBLE_COUNT_EN.
module id_ex_register #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned VEC_BEATS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         StallE,
  input  logic                         FlushE,
  input  logic                         PCSrcD,
  input  logic                         RegWriteD,
  input  logic                         MemtoRegD,
  input  logic                         MemWriteD,
  input  logic [2:0]                   ALUControlD,
  input  logic                         ALUSelD,
  input  logic                         BranchD,
  input  logic                         ALUSrcD,
  input  logic [1:0]                   FlagWriteD,
  input  logic [WIDTH-1:0]             RD1D,
  input  logic [WIDTH-1:0]             RD2D,
  input  logic [WIDTH-1:0]             ExtImmD,
  input  logic [3:0]                   WA3D,
  output logic                         PCSrcE,
  output logic                         RegWriteE,
  output logic                         MemtoRegE,
  output logic                         MemWriteE,
  output logic [2:0]                   ALUControlE,
  output logic                         ALUSelE,
  output logic                         BranchE,
  output logic                         ALUSrcE,
  output logic [1:0]                   FlagWriteE,
  output logic [WIDTH-1:0]             RD1E,
  output logic [WIDTH-1:0]             RD2E,
  output logic [WIDTH-1:0]             ExtImmE,
  output logic [3:0]                   WA3E,
  output logic [$clog2(VEC_BEATS)-1:0] BeatE,
  output logic                         LastBeatE,
  output logic                         Stuck,
  output logic [15:0]                  BubbleCount
);

  localparam int unsigned BEAT_W = $clog2(VEC_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(VEC_BEATS - 1);

  typedef enum logic {IDLE, VEC} state_e;

  state_e             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               pcsrc_q, pcsrc_d;
  logic               regwrite_q, regwrite_d;
  logic               memtoreg_q, memtoreg_d;
  logic               memwrite_q, memwrite_d;
  logic [2:0]         aluctrl_q, aluctrl_d;
  logic               alusel_q, alusel_d;
  logic               branch_q, branch_d;
  logic               alusrc_q, alusrc_d;
  logic [1:0]         flagwrite_q, flagwrite_d;
  logic [WIDTH-1:0]   rd1_q, rd1_d;
  logic [WIDTH-1:0]   rd2_q, rd2_d;
  logic [WIDTH-1:0]   extimm_q, extimm_d;
  logic [3:0]         wa3_q, wa3_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      pcsrc_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      aluctrl_q   <= '0;
      alusel_q    <= 1'b0;
      branch_q    <= 1'b0;
      alusrc_q    <= 1'b0;
      flagwrite_q <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      extimm_q    <= '0;
      wa3_q       <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      pcsrc_q     <= pcsrc_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      memwrite_q  <= memwrite_d;
      aluctrl_q   <= aluctrl_d;
      alusel_q    <= alusel_d;
      branch_q    <= branch_d;
      alusrc_q    <= alusrc_d;
      flagwrite_q <= flagwrite_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      extimm_q    <= extimm_d;
      wa3_q       <= wa3_d;
    end
  end

  // Next state: flush beats stall; a vector op holds its payload until its last beat.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    pcsrc_d     = pcsrc_q;
    regwrite_d  = regwrite_q;
    memtoreg_d  = memtoreg_q;
    memwrite_d  = memwrite_q;
    aluctrl_d   = aluctrl_q;
    alusel_d    = alusel_q;
    branch_d    = branch_q;
    alusrc_d    = alusrc_q;
    flagwrite_d = flagwrite_q;
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    extimm_d    = extimm_q;
    wa3_d       = wa3_q;
    if (FlushE) begin
      state_d     = IDLE;
      beat_d      = '0;
      pcsrc_d     = 1'b0;
      regwrite_d  = 1'b0;
      memtoreg_d  = 1'b0;
      memwrite_d  = 1'b0;
      aluctrl_d   = '0;
      alusel_d    = 1'b0;
      branch_d    = 1'b0;
      alusrc_d    = 1'b0;
      flagwrite_d = '0;
      rd1_d       = '0;
      rd2_d       = '0;
      extimm_d    = '0;
      wa3_d       = '0;
    end else if (!StallE) begin
      if (state_q == IDLE || beat_q == LAST_BEAT) begin
        state_d     = ALUSelD ? VEC : IDLE;
        beat_d      = '0;
        pcsrc_d     = PCSrcD;
        regwrite_d  = RegWriteD;
        memtoreg_d  = MemtoRegD;
        memwrite_d  = MemWriteD;
        aluctrl_d   = ALUControlD;
        alusel_d    = ALUSelD;
        branch_d    = BranchD;
        alusrc_d    = ALUSrcD;
        flagwrite_d = FlagWriteD;
        rd1_d       = RD1D;
        rd2_d       = RD2D;
        extimm_d    = ExtImmD;
        wa3_d       = WA3D;
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end
  end

  assign PCSrcE      = pcsrc_q;
  assign RegWriteE   = regwrite_q;
  assign MemtoRegE   = memtoreg_q;
  assign MemWriteE   = memwrite_q;
  assign ALUControlE = aluctrl_q;
  assign ALUSelE     = alusel_q;
  assign BranchE     = branch_q;
  assign ALUSrcE     = alusrc_q;
  assign FlagWriteE  = flagwrite_q;
  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign ExtImmE     = extimm_q;
  assign WA3E        = wa3_q;
  assign BeatE       = beat_q;
  assign LastBeatE   = (state_q == IDLE) || (beat_q == LAST_BEAT);
  assign Stuck       = (state_q == VEC) && (beat_q != LAST_BEAT);

`ifdef IDEX_BUBBLE_COUNT_EN
  logic [15:0] bubble_q, bubble_d;

  // Saturating count of flush-inserted bubbles.
  always_comb begin
    bubble_d = bubble_q;
    if (FlushE && bubble_q != 16'hFFFF) bubble_d = bubble_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bubble_q <= '0;
    else      bubble_q <= bubble_d;
  end

  assign BubbleCount = bubble_q;
`else
  assign BubbleCount = '0;
`endif

endmodule
